spi_read_arbiter: RTL and testbench

- Round-robin arbiter that shares one SPI read engine among N requesters.
- The engine uses a level rd / d_ready / 16-bit d handshake and runs from a divided SCLK domain.
- The arbiter sequences each transaction: issue rd, wait for d_ready, capture d, drop rd, wait for d_ready to clear.
- It then returns the captured word to the granted requester with a one-cycle done pulse. It sits between application logic (sensor pollers, display refresh) and the SPI read engine.

---
 rtl/spi_read_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_read_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_read_arbiter.sv
// spi_read_arbiter: round-robin arbiter sharing one SPI read engine among N requesters.
// Each transaction: raise spi_rd, wait for synchronized d_ready, capture spi_d, drop
// spi_rd, wait for d_ready to clear, then pulse done to the granted requester.
// Optional ISSUE-state timeout is built only when SPI_ARB_TIMEOUT_EN is defined.
//
// Handshake: spi_rd_o is a level request; the engine raises spi_d_ready_i once spi_d_i
// is stable and holds it until it sees spi_rd_o low. On the requester side req_i is a
// level held until the matching done_o bit pulses; done_o and rd_data_o are valid together.
module spi_read_arbiter #(
    parameter int N           = 4,
    parameter int DW          = 16,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          clk_i,
    input  logic          rst_l_i,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [N-1:0]  done_o,
    output logic [DW-1:0] rd_data_o,
    output logic          timeout_o,
    output logic          busy_o,
    output logic          spi_rd_o,
    input  logic          spi_d_ready_i,
    input  logic [DW-1:0] spi_d_i,
    output logic [1:0]    state_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Parameter sanity: the requester index and the timeout counter assume these ranges.
    if (N < 2 || N > 8 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("spi_read_arbiter: N must be 2..8 and TIMEOUT_CYC at least 2");
    end

    state_t          state_q;
    logic [N-1:0]    gnt_q;
    logic [N-1:0]    done_q;
    logic [DW-1:0]   rd_data_q;
    logic            busy_q;
    logic            spi_rd_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   idx_q;
    logic            rdy_meta_q;
    logic            rdy_s_q;

    logic [N-1:0]    req_eff;
    logic            arb_found_d;
    logic [IW-1:0]   arb_idx_d;
    logic [IW-1:0]   ptr_d;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TCW-1:0]  cnt_q;
    logic            to_flag_q;
    logic            timeout_q;
`endif

    // Round-robin search upward from the pointer with wrap; the requester whose done is
    // pulsing this cycle is masked so a req still high at done is not re-granted at once.
    always_comb begin
        req_eff     = req_i & ~done_q;
        arb_found_d = 1'b0;
        arb_idx_d   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            int            cand;
            logic [IW-1:0] cidx;
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cidx = IW'(cand);
            if (req_eff[cidx]) begin
                arb_found_d = 1'b1;
                arb_idx_d   = cidx;
            end
        end
        ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
    end

    // Transaction sequencer, d_ready synchronizer and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_l_i) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            rd_data_q  <= '0;
            busy_q     <= 1'b0;
            spi_rd_q   <= 1'b0;
            ptr_q      <= '0;
            idx_q      <= '0;
            rdy_meta_q <= 1'b0;
            rdy_s_q    <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            to_flag_q  <= 1'b0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            rdy_meta_q <= spi_d_ready_i;
            rdy_s_q    <= rdy_meta_q;
            done_q     <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            timeout_q  <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (arb_found_d) begin
                        gnt_q    <= N'(1) << arb_idx_d;
                        idx_q    <= arb_idx_d;
                        spi_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_ISSUE;
`ifdef SPI_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
                        to_flag_q <= 1'b0;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (rdy_s_q) begin
                        rd_data_q <= spi_d_i;
                        spi_rd_q  <= 1'b0;
                        state_q   <= ST_RELEASE;
                    end
`ifdef SPI_ARB_TIMEOUT_EN
                    else if (cnt_q == TCW'(TIMEOUT_CYC - 1)) begin
                        // Abort: rd_data keeps its previous word.
                        spi_rd_q  <= 1'b0;
                        to_flag_q <= 1'b1;
                        state_q   <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                ST_RELEASE: begin
                    if (!rdy_s_q) begin
                        done_q  <= gnt_q;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= ptr_d;
                        state_q <= ST_IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
                        timeout_q <= to_flag_q;
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign spi_rd_o  = spi_rd_q;
    assign state_o   = state_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_read_arbiter.sv
// Testbench for spi_read_arbiter: engine model with a divided-SCLK response delay,
// scoreboard of expected {timeout, done one-hot, word} popped on every done pulse.
// Define SPI_ARB_TIMEOUT_EN to also exercise the ISSUE-state abort.
module tb_spi_read_arbiter;

    localparam int N       = 4;
    localparam int DW      = 16;
    localparam int TO_CYC  = 64;
    localparam int ENG_DLY = 32;  // 8 SCLK periods at clk/4

    logic          clk;
    logic          rst_l;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [DW-1:0] rd_data;
    logic          timeout;
    logic          busy;
    logic          spi_rd;
    logic          spi_d_ready;
    logic [DW-1:0] spi_d;
    logic [1:0]    state;

    logic [20:0]   exp_q[$];
    logic [DW-1:0] eng_q[$];
    bit            eng_en;
    bit            eng_abort;
    bit            timeout_seen;
    int            n_vec;
    int            n_err;

    spi_read_arbiter #(
        .N(N), .DW(DW), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk_i(clk), .rst_l_i(rst_l), .req_i(req), .gnt_o(gnt), .done_o(done),
        .rd_data_o(rd_data), .timeout_o(timeout), .busy_o(busy), .spi_rd_o(spi_rd),
        .spi_d_ready_i(spi_d_ready), .spi_d_i(spi_d), .state_o(state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Engine model: responds to a level spi_rd after ENG_DLY clocks, off the clk edge.
    initial begin
        spi_d_ready = 1'b0;
        spi_d       = '0;
    end
    always begin
        @(posedge clk);
        if (spi_rd && eng_en) begin
            eng_abort = 1'b0;
            for (int i = 0; i < ENG_DLY; i++) begin
                @(posedge clk);
                if (!spi_rd) eng_abort = 1'b1;
            end
            if (!eng_abort) begin
                #3;
                spi_d       = (eng_q.size() > 0) ? eng_q.pop_front() : 16'hDEAD;
                spi_d_ready = 1'b1;
                for (int i = 0; i < 1000 && spi_rd; i++) @(posedge clk);
                repeat (4) @(posedge clk);
                #3;
                spi_d_ready = 1'b0;
            end
        end
    end

    // Scoreboard: every done pulse must match the head of the expected queue.
    always @(negedge clk) begin
        if (timeout) timeout_seen = 1'b1;
        if (done != '0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                check("done_idx", done, e[19:16]);
                check("rd_data", rd_data, e[15:0]);
                check("timeout_flag", timeout, e[20]);
            end
        end
    end

    // Wait for done[k] (bounded), then optionally have requester k drop its request.
    task automatic wait_done(input int k, input bit drop);
        int n;
        n = 0;
        while (!done[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!done[k]) check("done_wait_expired", done[k], 1);
        if (drop) req[k] = 1'b0;
    endtask

    task automatic wait_any_done();
        int n;
        @(negedge clk);
        n = 0;
        while (done == '0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (done == '0) check("any_done_expired", done, 1);
    endtask

    task automatic push_txn(input logic [N-1:0] oh, input logic [DW-1:0] w, input bit to);
        if (!to) eng_q.push_back(w);
        exp_q.push_back({to, oh, w});
    endtask

    initial begin
        logic [DW-1:0] last_word;
        n_vec        = 0;
        n_err        = 0;
        eng_en       = 1'b1;
        timeout_seen = 1'b0;
        rst_l        = 1'b0;
        req          = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_spi_rd", spi_rd, 0);
        check("rst_state", state, 0);
        rst_l = 1'b1;

        // Single request from requester 1
        push_txn(4'b0010, 16'hA5C3, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        check("single_gnt", gnt, 4'b0010);
        check("single_spi_rd", spi_rd, 1);
        check("single_busy", busy, 1);
        wait_done(1, 1'b1);
        @(negedge clk);
        check("single_gnt_clr", gnt, 0);
        check("single_busy_clr", busy, 0);

        // Pointer is now 2: req 1 and 2 together must grant 2
        push_txn(4'b0100, 16'h1234, 1'b0);
        req = 4'b0110;
        @(negedge clk);
        check("ptr2_gnt", gnt, 4'b0100);
        wait_done(2, 1'b1);
        req = '0;

        // Pointer is now 3: wrap and priority, 3 then 0
        push_txn(4'b1000, 16'hB003, 1'b0);
        push_txn(4'b0001, 16'hB000, 1'b0);
        req = 4'b1001;
        @(negedge clk);
        check("wrap_gnt_first", gnt, 4'b1000);
        wait_done(3, 1'b1);
        wait_done(0, 1'b1);
        last_word = 16'hB000;

        // Fresh reset, then all four requesting continuously: order 0,1,2,3,0
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
        check("rst2_rd_data", rd_data, 0);
        for (int i = 0; i < 5; i++) begin
            logic [N-1:0] oh;
            oh = N'(1) << (i % N);
            push_txn(oh, 16'(i + 1), 1'b0);
        end
        req = 4'b1111;
        for (int i = 0; i < 5; i++) wait_any_done();
        req = '0;
        repeat (3) @(negedge clk);
        check("all_busy_after", busy, 0);

        // Reset while in ISSUE: no done, outputs cleared, requester 0 first afterwards
        req = 4'b0100;
        for (int n = 0; n < 100 && state != 2'd1; n++) @(negedge clk);
        check("mid_in_issue", state, 2'd1);
        repeat (3) @(negedge clk);
        rst_l = 1'b0;
        req   = '0;
        @(negedge clk);
        rst_l = 1'b1;
        check("mid_spi_rd", spi_rd, 0);
        check("mid_gnt", gnt, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        repeat (ENG_DLY + 4) @(negedge clk);
        push_txn(4'b0001, 16'hC000, 1'b0);
        push_txn(4'b0100, 16'hC002, 1'b0);
        req = 4'b0101;
        @(negedge clk);
        check("mid_regrant", gnt, 4'b0001);
        wait_done(0, 1'b1);
        wait_done(2, 1'b1);

        // Request dropped while granted still completes
        push_txn(4'b0010, 16'hD00D, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        check("drop_gnt", gnt, 4'b0010);
        req = '0;
        wait_done(1, 1'b0);
        last_word = 16'hD00D;

`ifdef SPI_ARB_TIMEOUT_EN
        // Engine silent: abort after TIMEOUT_CYC cycles in ISSUE, rd_data unchanged
        begin
            int n;
            repeat (4) @(negedge clk);
            eng_en = 1'b0;
            push_txn(4'b0100, last_word, 1'b1);
            req = 4'b0100;
            @(negedge clk);
            check("to_spi_rd_up", spi_rd, 1);
            n = 0;
            while (spi_rd && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("to_issue_cycles", n, TO_CYC);
            wait_done(2, 1'b1);
            eng_en = 1'b1;
        end
`else
        check("timeout_never", timeout_seen, 0);
`endif

        repeat (10) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
